switch_input_port: RTL and testbench
====================================

Name: switch_input_port

Overview:
Parametrised input port for the board switches feeding the processor system. Each channel gets a synchroniser, a per-channel debounce counter, and edge detection into a write-one-to-clear pending register with a maskable interrupt. It replaces raw switch wiring into the system top and generalises it to N channels with selectable edge mode.

Parameters:
NUM_CH, 8, number of switch channels (1..32)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable clocks required to accept a new level (>=1)
EDGE_MODE, 0, event qualification: 0 both edges, 1 rising only, 2 falling only
RESET_STATE, 0, reset value of synchroniser flops and debounced state (NUM_CH bits)
COUNT_W, 16, width of event counter (optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
sw_in  input  NUM_CH  raw asynchronous switch pins
irq_mask  input  NUM_CH  per-channel interrupt enable
clr_valid  input  1  one-cycle strobe, apply clr_mask this edge
clr_mask  input  NUM_CH  write-one-to-clear mask for pending bits
sw_state  output  NUM_CH  debounced switch levels (registered)
pending  output  NUM_CH  latched qualifying-edge flags (registered)
irq  output  1  registered OR of pending & irq_mask
event_count  output  COUNT_W  total qualifying events (optional feature)

Behaviour:
- Reset (rst=0, async): sync flops and sw_state = RESET_STATE; debounce counters = 0; pending = 0; irq = 0; event_count = 0. All hold while rst=0.
- Synchroniser: SYNC_STAGES flop chain per bit; the last stage is sync[i].
- Debounce, per channel: if sync[i] == sw_state[i], counter clears. Otherwise counter increments. On the edge where the counter would reach DEBOUNCE_CYCLES, sw_state[i] takes sync[i] and the counter clears. Any return to equality before then clears the counter; no partial credit is kept.
- Latency: a clean pin change appears on sw_state exactly SYNC_STAGES + DEBOUNCE_CYCLES edges after the first edge that samples the new level.
- Event: chg[i] is asserted on the edge where sw_state[i] updates. It is qualified by EDGE_MODE using the new value: mode 1 requires new=1, mode 2 requires new=0.
- Pending: on each edge, pending <= (pending & ~(clr_valid ? clr_mask : 0)) | evt. If a set and a clear hit the same bit on the same edge, the set wins and the bit stays 1. clr_mask bits with no pending flag have no effect.
- irq: on each edge, irq <= |(pending_next & irq_mask). It therefore rises on the same edge the pending bit is set. Changing irq_mask alone affects irq one edge later.
- Reset asserted mid-debounce abandons the count. After release, a channel whose pin differs from RESET_STATE debounces from zero and produces a qualifying event.
- No combinational path from any input to any output.

Optional Feature:
SW_EVENT_COUNT_EN
- Defined: event_count increments by the number of channels with a qualifying event on that edge (popcount) and saturates at all-ones. It is cleared only by reset.
- Undefined: event_count is tied to 0 and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset/startup (NUM_CH=8, RESET_STATE=0, sw_in=8'hFF held through reset): during rst=0, sw_state=0, pending=0, irq=0. After release, sw_state=8'hFF on exactly the 6th edge. pending=8'hFF (EDGE_MODE 0). irq=1 iff irq_mask!=0.
- Glitch reject: sw_in[3] high for 3 cycles then low -> sw_state[3] stays 0, pending[3] stays 0, counter back to 0. A subsequent 4-cycle-plus high -> sw_state[3]=1 6 edges after the rise.
- Bounce: sw_in[2] toggles every 2 cycles for 20 cycles, then holds 1 -> sw_state[2] rises exactly once, 6 edges after the final transition. pending[2] is set once and irq_mask[2]=1 gives irq=1 on that edge.
- Clear/set collision: pending[5]=1; pulse clr_valid with clr_mask=8'h20 on the same edge a new event sets bit 5 -> pending[5]=1. A later clear with no event -> pending[5]=0 and irq falls on that edge (if no other masked bits).
- EDGE_MODE=1: bit0 1->0 debounced -> sw_state[0]=0, pending[0] unchanged. Bit0 0->1 -> pending[0]=1. With SW_EVENT_COUNT_EN, event_count increments by 1 only on the rise; 8 simultaneous rises -> +8.
- Reset mid-operation: assert rst after 2 of 4 debounce cycles on bit7 -> sw_state[7]=0, pending=0 immediately. After release with pin held 1 -> full 6-edge latency, then pending[7]=1.

Source files
------------

// File: rtl/switch_input_port_if.sv
// Bus bundle for switch_input_port: raw pins, interrupt mask, W1C clear strobe and status outputs.
interface switch_input_port_if #(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned COUNT_W = 16
);
    logic [NUM_CH-1:0]  sw_in;
    logic [NUM_CH-1:0]  irq_mask;
    logic               clr_valid;
    logic [NUM_CH-1:0]  clr_mask;
    logic [NUM_CH-1:0]  sw_state;
    logic [NUM_CH-1:0]  pending;
    logic               irq;
    logic [COUNT_W-1:0] event_count;

    modport master (
        output sw_in, irq_mask, clr_valid, clr_mask,
        input  sw_state, pending, irq, event_count
    );

    modport slave (
        input  sw_in, irq_mask, clr_valid, clr_mask,
        output sw_state, pending, irq, event_count
    );
endinterface

// File: rtl/switch_input_port.sv
// N-channel switch input port: synchroniser, per-channel debounce, edge events into W1C pending + irq.
// Optional macro SW_EVENT_COUNT_EN adds a saturating popcount of qualifying events.
module switch_input_port #(
    parameter int unsigned       NUM_CH          = 8,
    parameter int unsigned       SYNC_STAGES     = 2,
    parameter int unsigned       DEBOUNCE_CYCLES = 4,
    parameter int unsigned       EDGE_MODE       = 0,
    parameter logic [NUM_CH-1:0] RESET_STATE     = '0,
    parameter int unsigned       COUNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    switch_input_port_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
    logic [NUM_CH-1:0] r_state;
    logic [NUM_CH-1:0] r_pend;
    logic              r_irq;
    logic [CNT_W-1:0]  r_cnt      [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_next [NUM_CH];
    logic [NUM_CH-1:0] w_sync;
    logic [NUM_CH-1:0] w_state_next;
    logic [NUM_CH-1:0] w_chg;
    logic [NUM_CH-1:0] w_evt;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_pend_next;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Metastability chain for the asynchronous pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) r_sync[s] <= RESET_STATE;
        end else begin
            r_sync[0] <= bus.sw_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        w_state_next = r_state;
        w_chg        = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_cnt_next[i] = '0;
            if (w_sync[i] != r_state[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_state_next[i] = w_sync[i];
                    w_chg[i]        = 1'b1;
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_evt = w_chg;
        if (EDGE_MODE == 1)      w_evt = w_chg & w_state_next;
        else if (EDGE_MODE == 2) w_evt = w_chg & ~w_state_next;
    end

    // Set wins over a same-edge clear
    assign w_clr       = bus.clr_valid ? bus.clr_mask : '0;
    assign w_pend_next = (r_pend & ~w_clr) | w_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RESET_STATE;
            r_pend  <= '0;
            r_irq   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_irq   <= |(w_pend_next & bus.irq_mask);
            for (int unsigned i = 0; i < NUM_CH; i++) r_cnt[i] <= w_cnt_next[i];
        end
    end

    assign bus.sw_state = r_state;
    assign bus.pending  = r_pend;
    assign bus.irq      = r_irq;

`ifdef SW_EVENT_COUNT_EN
    localparam int unsigned PC_W  = $clog2(NUM_CH + 1);
    localparam int unsigned SUM_W = COUNT_W + 1;

    logic [PC_W-1:0]    w_pc;
    logic [SUM_W-1:0]   w_sum;
    logic [COUNT_W-1:0] r_count;

    always_comb begin
        w_pc = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) w_pc = w_pc + PC_W'(w_evt[i]);
    end

    assign w_sum = {1'b0, r_count} + SUM_W'(w_pc);

    // Saturate at all-ones; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                r_count <= '0;
        else if (w_sum[COUNT_W]) r_count <= '1;
        else                     r_count <= w_sum[COUNT_W-1:0];
    end

    assign bus.event_count = r_count;
`else
    assign bus.event_count = COUNT_W'(0);
`endif
endmodule

// File: tb/tb_switch_input_port.sv
// Scoreboard bench for switch_input_port: a default-mode DUT plus a rising-edge-only DUT.
module tb_switch_input_port;
    localparam int unsigned N  = 8;
    localparam int unsigned CW = 16;
`ifdef SW_EVENT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // v = {sw_state, pending, irq}; d1 selects the EDGE_MODE=1 instance
    typedef struct {
        string       name;
        bit          d1;
        logic [16:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [16:0] got;
    int          n_vec  = 0;
    int          n_miss = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    switch_input_port_if #(.NUM_CH(N), .COUNT_W(CW)) u_if  ();
    switch_input_port_if #(.NUM_CH(N), .COUNT_W(CW)) u_if1 ();

    switch_input_port #(.NUM_CH(N), .COUNT_W(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    switch_input_port #(.NUM_CH(N), .EDGE_MODE(1), .COUNT_W(CW)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_if1.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] obs0();
        return {u_if.sw_state, u_if.pending, u_if.irq};
    endfunction

    function automatic logic [16:0] obs1();
        return {u_if1.sw_state, u_if1.pending, u_if1.irq};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input bit d1, input logic [16:0] v);
        exp_t x;
        x.name = n;
        x.d1   = d1;
        x.v    = v;
        sb.push_back(x);
    endtask

    task automatic do_reset(input logic [7:0] sw0, input logic [7:0] m0,
                            input logic [7:0] sw1, input logic [7:0] m1);
        rst               = 1'b0;
        u_if.sw_in        = sw0;
        u_if.irq_mask     = m0;
        u_if.clr_valid    = 1'b0;
        u_if.clr_mask     = '0;
        u_if1.sw_in       = sw1;
        u_if1.irq_mask    = m1;
        u_if1.clr_valid   = 1'b0;
        u_if1.clr_mask    = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst             = 1'b0;
        u_if.sw_in      = 8'hFF;
        u_if.irq_mask   = 8'h01;
        u_if.clr_valid  = 1'b0;
        u_if.clr_mask   = '0;
        u_if1.sw_in     = '0;
        u_if1.irq_mask  = '0;
        u_if1.clr_valid = 1'b0;
        u_if1.clr_mask  = '0;
        for (int k = 0; k < 3; k++) begin
            push("reset_hold", 1'b0, {8'h00, 8'h00, 1'b0});
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
        end
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            push("reset_release", 1'b0, (k == 6) ? {8'hFF, 8'hFF, 1'b1} : 17'h0);
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        n_vec++;
        if (u_if.event_count !== (CNT_EN ? CW'(8) : CW'(0))) begin
            n_miss++; $display("FAIL reset_count: got %0d exp %0d", u_if.event_count, CNT_EN ? 8 : 0);
        end
    endtask

    task automatic test_glitch();
        do_reset(8'h00, 8'h08, 8'h00, 8'h00);
        for (int k = 0; k < 11; k++) begin
            u_if.sw_in = (k < 3) ? 8'h08 : 8'h00;
            push("glitch_reject", 1'b0, 17'h0);
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s cyc %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        u_if.sw_in = 8'h08;
        for (int k = 1; k <= 6; k++) begin
            push("glitch_accept", 1'b0, (k == 6) ? {8'h08, 8'h08, 1'b1} : 17'h0);
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
    endtask

    task automatic test_bounce();
        do_reset(8'h00, 8'h04, 8'h00, 8'h00);
        for (int i = 0; i < 20; i++) begin
            u_if.sw_in = (((i / 2) % 2) == 0) ? 8'h04 : 8'h00;
            push("bounce", 1'b0, 17'h0);
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s cyc %0d: got %h exp %h", e.name, i, got, e.v); end
        end
        u_if.sw_in = 8'h04;
        for (int k = 1; k <= 9; k++) begin
            push("bounce_settle", 1'b0, (k >= 6) ? {8'h04, 8'h04, 1'b1} : 17'h0);
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
    endtask

    task automatic test_collision();
        do_reset(8'h00, 8'h20, 8'h00, 8'h00);
        u_if.sw_in = 8'h20;
        for (int k = 1; k <= 6; k++) begin
            push("coll_rise", 1'b0, (k == 6) ? {8'h20, 8'h20, 1'b1} : 17'h0);
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        u_if.clr_valid = 1'b1;
        u_if.clr_mask  = 8'h01;
        push("clr_unpended", 1'b0, {8'h20, 8'h20, 1'b1});
        tick();
        u_if.clr_valid = 1'b0;
        e = sb.pop_front(); got = obs0(); n_vec++;
        if (got !== e.v) begin n_miss++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
        u_if.sw_in = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) begin
                u_if.clr_valid = 1'b1;
                u_if.clr_mask  = 8'h20;
            end
            push("coll_fall", 1'b0, (k == 6) ? {8'h00, 8'h20, 1'b1} : {8'h20, 8'h20, 1'b1});
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        u_if.clr_valid = 1'b0;
        push("coll_idle", 1'b0, {8'h00, 8'h20, 1'b1});
        tick();
        e = sb.pop_front(); got = obs0(); n_vec++;
        if (got !== e.v) begin n_miss++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
        u_if.clr_valid = 1'b1;
        push("clr_only", 1'b0, {8'h00, 8'h00, 1'b0});
        tick();
        u_if.clr_valid = 1'b0;
        e = sb.pop_front(); got = obs0(); n_vec++;
        if (got !== e.v) begin n_miss++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
        u_if.sw_in = 8'h20;
        for (int k = 1; k <= 6; k++) begin
            push("mask_setup", 1'b0, (k == 6) ? {8'h20, 8'h20, 1'b1} : 17'h0);
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        u_if.irq_mask = 8'h00;
        push("mask_off", 1'b0, {8'h20, 8'h20, 1'b0});
        tick();
        e = sb.pop_front(); got = obs0(); n_vec++;
        if (got !== e.v) begin n_miss++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
    endtask

    task automatic test_edge_mode1();
        do_reset(8'h00, 8'h00, 8'h00, 8'hFF);
        u_if1.sw_in = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            push("m1_rise", 1'b1, (k == 6) ? {8'h01, 8'h01, 1'b1} : 17'h0);
            tick();
            e = sb.pop_front(); got = e.d1 ? obs1() : obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        n_vec++;
        if (u_if1.event_count !== (CNT_EN ? CW'(1) : CW'(0))) begin
            n_miss++; $display("FAIL m1_count_rise: got %0d exp %0d", u_if1.event_count, CNT_EN ? 1 : 0);
        end
        u_if1.clr_valid = 1'b1;
        u_if1.clr_mask  = 8'hFF;
        push("m1_clear", 1'b1, {8'h01, 8'h00, 1'b0});
        tick();
        u_if1.clr_valid = 1'b0;
        e = sb.pop_front(); got = e.d1 ? obs1() : obs0(); n_vec++;
        if (got !== e.v) begin n_miss++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
        u_if1.sw_in = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            push("m1_fall", 1'b1, (k == 6) ? 17'h0 : {8'h01, 8'h00, 1'b0});
            tick();
            e = sb.pop_front(); got = e.d1 ? obs1() : obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        n_vec++;
        if (u_if1.event_count !== (CNT_EN ? CW'(1) : CW'(0))) begin
            n_miss++; $display("FAIL m1_count_fall: got %0d exp %0d", u_if1.event_count, CNT_EN ? 1 : 0);
        end
        u_if1.sw_in = 8'hFF;
        for (int k = 1; k <= 6; k++) begin
            push("m1_all_rise", 1'b1, (k == 6) ? {8'hFF, 8'hFF, 1'b1} : 17'h0);
            tick();
            e = sb.pop_front(); got = e.d1 ? obs1() : obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        n_vec++;
        if (u_if1.event_count !== (CNT_EN ? CW'(9) : CW'(0))) begin
            n_miss++; $display("FAIL m1_count_all: got %0d exp %0d", u_if1.event_count, CNT_EN ? 9 : 0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(8'h00, 8'h80, 8'h00, 8'h00);
        u_if.sw_in = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            push("mid_pre", 1'b0, (k == 6) ? {8'h01, 8'h01, 1'b0} : 17'h0);
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        u_if.sw_in = 8'h81;
        for (int k = 1; k <= 4; k++) begin
            push("mid_partial", 1'b0, {8'h01, 8'h01, 1'b0});
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        push("mid_async_rst", 1'b0, 17'h0);
        rst = 1'b0;
        #1;
        e = sb.pop_front(); got = obs0(); n_vec++;
        if (got !== e.v) begin n_miss++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
        tick();
        tick();
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            push("mid_release", 1'b0, (k == 6) ? {8'h81, 8'h81, 1'b1} : 17'h0);
            tick();
            e = sb.pop_front(); got = obs0(); n_vec++;
            if (got !== e.v) begin n_miss++; $display("FAIL %s edge %0d: got %h exp %h", e.name, k, got, e.v); end
        end
        n_vec++;
        if (u_if.event_count !== (CNT_EN ? CW'(2) : CW'(0))) begin
            n_miss++; $display("FAIL mid_count: got %0d exp %0d", u_if.event_count, CNT_EN ? 2 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_glitch();
        test_bounce();
        test_collision();
        test_edge_mode1();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
